yamali_baslangic_bellegi: RTL and testbench
===========================================

Name: yamali_baslangic_bellegi

Overview:
Parametrised successor to the fixed boot ROM: a read-only boot image of configurable width and depth with a registered, pipelined read path.
- Adds valid/stall handshake, address-error detection and a small lockable patch table that overrides individual ROM words.
- Sits between the core fetch unit and the boot image; patches are loaded by the management side before the core leaves reset, then locked.

Parameters:
VERI_W, 32, instruction/data word width in bits
DERINLIK, 64, ROM words (image index 0..DERINLIK-1)
ADRES_W, 32, byte address width
YAMA_SAYISI, 4, patch slots (1..8)
BEKLEME, 1, read latency in cycles (1 or 2)

Ports:
clk_g  in  1  clock; all state updates on rising edge
rst_g  in  1  synchronous reset, active-high
istek_g  in  1  read request
adres_g  in  ADRES_W  byte address of request
durdur_g  in  1  consumer stall; holds the output stage
hazir_c  out  1  request accepted this cycle when istek_g && hazir_c
buyruk_c  out  VERI_W  read word
gecerli_c  out  1  buyruk_c valid
hata_c  out  1  qualifies buyruk_c: misaligned or out-of-range access
yama_yaz_g  in  1  patch slot write strobe
yama_sec_g  in  $clog2(YAMA_SAYISI)  slot select
yama_adres_g  in  $clog2(DERINLIK)  word index to override
yama_veri_g  in  VERI_W  replacement word
yama_kilit_g  in  1  lock request (sticky)
yama_hata_c  out  1  one-cycle pulse: write rejected

Behaviour:
- Reset (rst_g sampled high): buyruk_c = ROM[0], gecerli_c=0, hata_c=0, yama_hata_c=0, all slots invalid, lock cleared, pipeline emptied.
- Reset mid-read discards in-flight requests; no valid output follows.
- Word index = adres_g >> 2.
  - adres_g[1:0] != 0 or index >= DERINLIK -> error access: hata_c=1 with gecerli_c, buyruk_c = NOP constant 0x00000013.
  - Upper index bits are never truncated into range.
- hazir_c = !durdur_g.
  - Accepted request appears at the output exactly BEKLEME cycles later when no stall occurs.
  - One request per cycle, fully pipelined.
- Stall: while durdur_g=1, all pipeline stages and outputs hold; gecerli_c/buyruk_c/hata_c remain stable.
- Cycles without an accepted request produce a bubble: gecerli_c=0, buyruk_c holds its last value.
- Patch lookup (combinational, on accepted index):
  - A valid slot whose index matches replaces the ROM word.
  - Multiple matches: lowest-numbered slot wins.
  - Error accesses are never patched.
- Patch write: yama_yaz_g && !lock -> slot yama_sec_g gets {valid=1, index, data} at the next edge.
  - Overwriting a slot is allowed.
  - A read accepted in the same cycle sees the pre-write table.
- Lock FSM, 2 states:
  - ACIK -> KILITLI on yama_kilit_g.
  - KILITLI is left only via reset.
  - In KILITLI, yama_yaz_g is ignored and yama_hata_c pulses 1 the following cycle.
  - Write and lock in the same ACIK cycle: the write succeeds, lock takes effect afterwards.
- yama_sec_g >= YAMA_SAYISI: write ignored, yama_hata_c pulses.
- BEKLEME=2: stage 1 registers index+error flag, stage 2 registers data. BEKLEME=1: single register stage.

Decomposition:
- Package baslangic_paketi holds:
  - ROM image constant (array of VERI_W words, DERINLIK entries, unused words = NOP)
  - NOP constant
  - patch-slot struct {gecerli, indeks, veri}
  - lock state enum {ACIK, KILITLI}
- Sub-module yama_tablosu (slot registers, write/lock FSM, priority match) is natural.
- The top module keeps the address check, ROM index and pipeline.

Test Plan:
1. Reset, then BEKLEME=1, istek_g with adres_g=0x4 -> next cycle gecerli_c=1, buyruk_c=ROM[1], hata_c=0; directly after reset buyruk_c=ROM[0], gecerli_c=0.
2. Back-to-back requests 0x0,0x4,0x8 with BEKLEME=2 -> ROM[0..2] on consecutive cycles starting 2 cycles after first; durdur_g high 3 cycles mid-stream -> outputs frozen, no loss or duplicate.
3. adres_g=0x6 and adres_g=DERINLIK*4 -> gecerli_c=1, hata_c=1, buyruk_c=0x00000013.
4. Write slot2 {index 1, 0xDEADBEEF}, slot0 {index 1, 0x12345678}; read 0x4 -> 0x12345678; read issued same cycle as the first write -> ROM[1].
5. Assert yama_kilit_g, then write slot1 -> yama_hata_c=1 one cycle, table unchanged; rst_g -> lock cleared, patches gone, read 0x4 returns ROM[1].
6. Assert rst_g while two requests are in flight -> gecerli_c stays 0 until a new request completes.

Source files
------------

// File: rtl/yamali_baslangic_bellegi_pkg.sv
// Shared definitions for the patchable boot ROM: image contents, NOP word,
// patch-slot layout and the patch-table lock states.
package baslangic_paketi;

   localparam int ROM_VERI_W    = 32;
   localparam int ROM_DERINLIK  = 64;
   localparam int YAMA_INDEKS_W = $clog2(ROM_DERINLIK);

   // Returned for every error access and used to fill unused image words.
   localparam logic [ROM_VERI_W-1:0] NOP = 32'h0000_0013;

   typedef logic [ROM_VERI_W-1:0] rom_imaj_t [ROM_DERINLIK];

   // Boot stub: set up a trap vector and a stack pointer, then spin.
   localparam rom_imaj_t ROM_IMAJ = '{
      0:       32'h0000_0297,  // auipc t0, 0
      1:       32'h0202_8293,  // addi  t0, t0, 32
      2:       32'h3052_9073,  // csrw  mtvec, t0
      3:       32'h0000_1137,  // lui   sp, 1
      4:       32'h0000_006f,  // j     .
      default: NOP
   };

   typedef struct packed {
      logic                     gecerli;
      logic [YAMA_INDEKS_W-1:0] indeks;
      logic [ROM_VERI_W-1:0]    veri;
   } yama_slot_t;

   typedef enum logic {ACIK, KILITLI} kilit_e;

   // Image lookup that yields NOP for indices beyond the stored image.
   function automatic logic [ROM_VERI_W-1:0] rom_oku(input int unsigned i);
      return (i < ROM_DERINLIK) ? ROM_IMAJ[i[YAMA_INDEKS_W-1:0]] : NOP;
   endfunction

endpackage

// File: rtl/yamali_baslangic_bellegi_yama_tablosu.sv
// Patch table: a few {valid, index, word} slots written by the management
// side until locked; lookup is combinational with lowest slot winning.
module yama_tablosu
   import baslangic_paketi::*;
#(
   parameter int VERI_W      = ROM_VERI_W,
   parameter int IDX_W       = YAMA_INDEKS_W,
   parameter int YAMA_SAYISI = 4,
   parameter int SEC_W       = 2
) (
   input  logic              clk_g,
   input  logic              rst_g,
   input  logic              yaz_g,
   input  logic [SEC_W-1:0]  sec_g,
   input  logic [IDX_W-1:0]  yaz_idx_g,
   input  logic [VERI_W-1:0] yaz_veri_g,
   input  logic              kilit_g,
   input  logic [IDX_W-1:0]  oku_idx_g,
   output logic              isabet_c,
   output logic [VERI_W-1:0] veri_c,
   output logic              red_c
);

   kilit_e     durum_q, durum_d;
   yama_slot_t slot_q [YAMA_SAYISI];
   logic       yaz_izin;
   logic       red_q;

   assign yaz_izin = yaz_g && (durum_q == ACIK) && (int'(sec_g) < YAMA_SAYISI);
   assign red_c    = red_q;

   // Lock state register.
   always_ff @(posedge clk_g) begin
      if (rst_g) durum_q <= ACIK;
      else       durum_q <= durum_d;
   end

   // Lock is sticky: once closed only reset reopens the table.
   always_comb begin
      durum_d = durum_q;
      case (durum_q)
         ACIK:    if (kilit_g) durum_d = KILITLI;
         KILITLI: durum_d = KILITLI;
      endcase
   end

   // A refused write (locked or bad slot) is reported one cycle later.
   always_ff @(posedge clk_g) begin
      if (rst_g) red_q <= 1'b0;
      else       red_q <= yaz_g && !yaz_izin;
   end

   // Slot storage; reads this cycle still see the old contents.
   always_ff @(posedge clk_g) begin
      if (rst_g) begin
         for (int i = 0; i < YAMA_SAYISI; i++) slot_q[i] <= '0;
      end else begin
         for (int i = 0; i < YAMA_SAYISI; i++)
            if (yaz_izin && int'(sec_g) == i)
               slot_q[i] <= '{gecerli: 1'b1,
                              indeks:  YAMA_INDEKS_W'(yaz_idx_g),
                              veri:    ROM_VERI_W'(yaz_veri_g)};
      end
   end

   // Priority match: scan high to low so the lowest matching slot is last to win.
   always_comb begin
      isabet_c = 1'b0;
      veri_c   = '0;
      for (int i = YAMA_SAYISI - 1; i >= 0; i--)
         if (slot_q[i].gecerli && (IDX_W'(slot_q[i].indeks) == oku_idx_g)) begin
            isabet_c = 1'b1;
            veri_c   = VERI_W'(slot_q[i].veri);
         end
   end

endmodule

// File: rtl/yamali_baslangic_bellegi.sv
// Patchable boot ROM: byte address -> word index with range/alignment check,
// patch override, and a 1- or 2-stage stallable read pipeline.
module yamali_baslangic_bellegi
   import baslangic_paketi::*;
#(
   parameter int VERI_W      = ROM_VERI_W,
   parameter int DERINLIK    = ROM_DERINLIK,
   parameter int ADRES_W     = 32,
   parameter int YAMA_SAYISI = 4,
   parameter int BEKLEME     = 1
) (
   input  logic                 clk_g,
   input  logic                 rst_g,
   input  logic                 istek_g,
   input  logic [ADRES_W-1:0]   adres_g,
   input  logic                 durdur_g,
   output logic                 hazir_c,
   output logic [VERI_W-1:0]    buyruk_c,
   output logic                 gecerli_c,
   output logic                 hata_c,
   input  logic                 yama_yaz_g,
   input  logic [((YAMA_SAYISI > 1) ? $clog2(YAMA_SAYISI) : 1)-1:0] yama_sec_g,
   input  logic [$clog2(DERINLIK)-1:0] yama_adres_g,
   input  logic [VERI_W-1:0]    yama_veri_g,
   input  logic                 yama_kilit_g,
   output logic                 yama_hata_c
);

   localparam int IDX_W = $clog2(DERINLIK);
   localparam int SEC_W = (YAMA_SAYISI > 1) ? $clog2(YAMA_SAYISI) : 1;
   // Full-width bound so high address bits can never alias into range.
   localparam logic [ADRES_W-3:0] SINIR = (ADRES_W-2)'(DERINLIK);

   logic               kabul;
   logic [ADRES_W-3:0] kelime;
   logic               giris_hata;
   logic [IDX_W-1:0]   giris_idx;
   logic               yama_isabet;
   logic [VERI_W-1:0]  yama_veri;

   // Source of the output stage (input side or stage 1, depending on latency).
   logic               k_vld, k_hata, k_yama;
   logic [IDX_W-1:0]   k_idx;
   logic [VERI_W-1:0]  k_yveri;

   logic [VERI_W-1:0]  buyruk_d, buyruk_q;
   logic               gecerli_q, hata_q;

   assign hazir_c    = !durdur_g;
   assign kabul      = istek_g && !durdur_g;
   assign kelime     = adres_g[ADRES_W-1:2];
   assign giris_hata = (adres_g[1:0] != 2'b00) || (kelime >= SINIR);
   assign giris_idx  = kelime[IDX_W-1:0];

   yama_tablosu #(
      .VERI_W(VERI_W), .IDX_W(IDX_W), .YAMA_SAYISI(YAMA_SAYISI), .SEC_W(SEC_W)
   ) u_yama (
      .clk_g      (clk_g),
      .rst_g      (rst_g),
      .yaz_g      (yama_yaz_g),
      .sec_g      (yama_sec_g),
      .yaz_idx_g  (yama_adres_g),
      .yaz_veri_g (yama_veri_g),
      .kilit_g    (yama_kilit_g),
      .oku_idx_g  (giris_idx),
      .isabet_c   (yama_isabet),
      .veri_c     (yama_veri),
      .red_c      (yama_hata_c)
   );

   if (BEKLEME == 2) begin : g_iki
      logic              s1_vld_q, s1_hata_q, s1_yama_q;
      logic [IDX_W-1:0]  s1_idx_q;
      logic [VERI_W-1:0] s1_yveri_q;

      // Stage 1: index, error flag and the patch result seen at acceptance.
      always_ff @(posedge clk_g) begin
         if (rst_g) begin
            s1_vld_q   <= 1'b0;
            s1_hata_q  <= 1'b0;
            s1_yama_q  <= 1'b0;
            s1_idx_q   <= '0;
            s1_yveri_q <= '0;
         end else if (!durdur_g) begin
            s1_vld_q   <= kabul;
            s1_hata_q  <= giris_hata;
            s1_yama_q  <= yama_isabet && !giris_hata;
            s1_idx_q   <= giris_idx;
            s1_yveri_q <= yama_veri;
         end
      end

      assign k_vld   = s1_vld_q;
      assign k_hata  = s1_hata_q;
      assign k_yama  = s1_yama_q;
      assign k_idx   = s1_idx_q;
      assign k_yveri = s1_yveri_q;
   end else begin : g_bir
      assign k_vld   = kabul;
      assign k_hata  = giris_hata;
      assign k_yama  = yama_isabet && !giris_hata;
      assign k_idx   = giris_idx;
      assign k_yveri = yama_veri;
   end

   // Word selection: error gives NOP, otherwise a patch overrides the image.
   always_comb begin
      buyruk_d = VERI_W'(rom_oku(32'(k_idx)));
      if (k_hata)      buyruk_d = VERI_W'(NOP);
      else if (k_yama) buyruk_d = k_yveri;
   end

   // Output stage: frozen on stall; a bubble drops valid but keeps the word.
   always_ff @(posedge clk_g) begin
      if (rst_g) begin
         gecerli_q <= 1'b0;
         hata_q    <= 1'b0;
         buyruk_q  <= VERI_W'(rom_oku(0));
      end else if (!durdur_g) begin
         gecerli_q <= k_vld;
         if (k_vld) begin
            buyruk_q <= buyruk_d;
            hata_q   <= k_hata;
         end
      end
   end

   assign buyruk_c  = buyruk_q;
   assign gecerli_c = gecerli_q;
   assign hata_c    = hata_q;

endmodule

// File: tb/tb_yamali_baslangic_bellegi.sv
// Scoreboard bench: the driver issues directed reads with hand-computed words;
// one monitor per latency variant pops and compares whenever output is valid.
module tb_yamali_baslangic_bellegi;

   localparam logic [31:0] ROM0 = 32'h0000_0297;
   localparam logic [31:0] ROM1 = 32'h0202_8293;
   localparam logic [31:0] ROM2 = 32'h3052_9073;
   localparam logic [31:0] ROM3 = 32'h0000_1137;
   localparam logic [31:0] ROM4 = 32'h0000_006f;
   localparam logic [31:0] NOPW = 32'h0000_0013;

   typedef struct {
      logic [31:0] veri;
      logic        hata;
      int          hedef;
   } ent_t;

   logic        clk_g = 1'b0;
   logic        rst_g, istek_g, durdur_g, yama_yaz_g, yama_kilit_g;
   logic [31:0] adres_g, yama_veri_g;
   logic [1:0]  yama_sec_g;
   logic [5:0]  yama_adres_g;
   logic [1:0]  hazir_w, gec_w, hata_w, yh_w;
   logic [31:0] buy_w [2];
   logic [31:0] bek_veri;
   logic        bek_hata;
   int          n_vek = 0;
   int          n_hata = 0;

   always #5 clk_g = ~clk_g;

   task automatic kontrol(input string ad, input int g, input logic [31:0] gercek,
                          input logic [31:0] beklenen);
      n_vek++;
      if (gercek !== beklenen) begin
         n_hata++;
         $display("FAIL %s (BEKLEME=%0d): got %h, expected %h", ad, g + 1, gercek, beklenen);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      yamali_baslangic_bellegi #(
         .VERI_W(32), .DERINLIK(64), .ADRES_W(32), .YAMA_SAYISI(4), .BEKLEME(g + 1)
      ) dut (
         .clk_g        (clk_g),
         .rst_g        (rst_g),
         .istek_g      (istek_g),
         .adres_g      (adres_g),
         .durdur_g     (durdur_g),
         .hazir_c      (hazir_w[g]),
         .buyruk_c     (buy_w[g]),
         .gecerli_c    (gec_w[g]),
         .hata_c       (hata_w[g]),
         .yama_yaz_g   (yama_yaz_g),
         .yama_sec_g   (yama_sec_g),
         .yama_adres_g (yama_adres_g),
         .yama_veri_g  (yama_veri_g),
         .yama_kilit_g (yama_kilit_g),
         .yama_hata_c  (yh_w[g])
      );

      ent_t        q[$];
      int          adv = 0;
      logic        rst_son = 1'b1;
      logic        adv_son = 1'b0;
      logic        son_gec = 1'b0;
      logic [31:0] son_veri = ROM0;

      // Accepted requests enter the scoreboard with their due advance count.
      always @(posedge clk_g) begin
         rst_son = rst_g;
         adv_son = !durdur_g;
         if (rst_g) begin
            q.delete();
            adv = 0;
         end else if (!durdur_g) begin
            adv++;
            if (istek_g) q.push_back('{veri: bek_veri, hata: bek_hata, hedef: adv + g});
         end
      end

      always @(negedge clk_g) begin
         ent_t e;
         kontrol("hazir", g, 32'(hazir_w[g]), 32'(!durdur_g));
         if (rst_son) begin
            kontrol("rst_gecerli", g, 32'(gec_w[g]), 32'd0);
            kontrol("rst_buyruk", g, buy_w[g], ROM0);
            kontrol("rst_hata", g, 32'(hata_w[g]), 32'd0);
            kontrol("rst_yama_hata", g, 32'(yh_w[g]), 32'd0);
            son_gec  = 1'b0;
            son_veri = ROM0;
         end else if (!adv_son) begin
            kontrol("durdur_gecerli", g, 32'(gec_w[g]), 32'(son_gec));
            kontrol("durdur_buyruk", g, buy_w[g], son_veri);
         end else if (gec_w[g]) begin
            if (q.size() == 0) begin
               n_vek++;
               n_hata++;
               $display("FAIL beklenmeyen_gecerli (BEKLEME=%0d): got valid word %h, expected no output",
                        g + 1, buy_w[g]);
            end else begin
               e = q.pop_front();
               kontrol("buyruk", g, buy_w[g], e.veri);
               kontrol("hata", g, 32'(hata_w[g]), 32'(e.hata));
               kontrol("gecikme", g, adv, e.hedef);
               son_veri = e.veri;
            end
            son_gec = 1'b1;
         end else begin
            kontrol("bosluk_buyruk", g, buy_w[g], son_veri);
            son_gec = 1'b0;
            if (q.size() > 0 && q[0].hedef <= adv) begin
               n_vek++;
               n_hata++;
               $display("FAIL kayip_cikti (BEKLEME=%0d): got no valid output, expected %h",
                        g + 1, q[0].veri);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic saat(input int n);
      repeat (n) @(posedge clk_g);
      #1;
   endtask

   task automatic gonder(input logic [31:0] a, input logic [31:0] v, input logic h);
      istek_g  = 1'b1;
      adres_g  = a;
      bek_veri = v;
      bek_hata = h;
      saat(1);
      istek_g  = 1'b0;
   endtask

   task automatic yama(input logic [1:0] s, input logic [5:0] i, input logic [31:0] v);
      yama_yaz_g   = 1'b1;
      yama_sec_g   = s;
      yama_adres_g = i;
      yama_veri_g  = v;
   endtask

   initial begin
      rst_g = 1'b1; istek_g = 1'b0; durdur_g = 1'b0; adres_g = '0;
      yama_yaz_g = 1'b0; yama_kilit_g = 1'b0; yama_sec_g = '0;
      yama_adres_g = '0; yama_veri_g = '0; bek_veri = '0; bek_hata = 1'b0;
      saat(3);
      rst_g = 1'b0;

      // Single read, then a stream with a 3-cycle stall and a refused request.
      gonder(32'h4, ROM1, 1'b0);
      saat(3);
      gonder(32'h0, ROM0, 1'b0);
      gonder(32'h4, ROM1, 1'b0);
      durdur_g = 1'b1; istek_g = 1'b1; adres_g = 32'hC; bek_veri = 32'hBAD0_BAD0;
      saat(3);
      durdur_g = 1'b0; istek_g = 1'b0;
      gonder(32'h8, ROM2, 1'b0);
      gonder(32'hC, ROM3, 1'b0);
      saat(3);

      // Error and boundary addresses.
      gonder(32'h6, NOPW, 1'b1);
      gonder(32'h100, NOPW, 1'b1);
      gonder(32'hFC, NOPW, 1'b0);
      gonder(32'h8000_0004, NOPW, 1'b1);
      saat(3);

      // Patches: same-cycle read sees the old table; lowest slot wins.
      yama(2'd2, 6'd1, 32'hDEAD_BEEF);
      gonder(32'h4, ROM1, 1'b0);
      yama(2'd0, 6'd1, 32'h1234_5678);
      gonder(32'h4, 32'hDEAD_BEEF, 1'b0);
      yama_yaz_g = 1'b0;
      for (int g = 0; g < 2; g++) kontrol("yama_hata_acik", g, 32'(yh_w[g]), 32'd0);
      gonder(32'h4, 32'h1234_5678, 1'b0);
      gonder(32'h5, NOPW, 1'b1);
      gonder(32'h8, ROM2, 1'b0);
      saat(3);

      // Write together with lock succeeds; later writes are refused.
      yama(2'd1, 6'd4, 32'hAAAA_5555);
      yama_kilit_g = 1'b1;
      saat(1);
      yama_yaz_g = 1'b0; yama_kilit_g = 1'b0;
      for (int g = 0; g < 2; g++) kontrol("yama_hata_kilit_ani", g, 32'(yh_w[g]), 32'd0);
      gonder(32'h10, 32'hAAAA_5555, 1'b0);
      yama(2'd1, 6'd2, 32'hCAFE_F00D);
      saat(1);
      yama_yaz_g = 1'b0;
      for (int g = 0; g < 2; g++) kontrol("yama_hata_darbe", g, 32'(yh_w[g]), 32'd1);
      saat(1);
      for (int g = 0; g < 2; g++) kontrol("yama_hata_bitis", g, 32'(yh_w[g]), 32'd0);
      gonder(32'h8, ROM2, 1'b0);
      gonder(32'h4, 32'h1234_5678, 1'b0);
      gonder(32'h10, 32'hAAAA_5555, 1'b0);
      saat(3);

      // Reset clears lock and patches.
      rst_g = 1'b1;
      saat(2);
      rst_g = 1'b0;
      gonder(32'h4, ROM1, 1'b0);
      gonder(32'h10, ROM4, 1'b0);
      yama(2'd3, 6'd3, 32'h1111_1111);
      saat(1);
      yama_yaz_g = 1'b0;
      for (int g = 0; g < 2; g++) kontrol("yama_hata_acildi", g, 32'(yh_w[g]), 32'd0);
      gonder(32'hC, 32'h1111_1111, 1'b0);
      saat(3);

      // Reset with reads in flight: nothing valid until a fresh read completes.
      gonder(32'h0, ROM0, 1'b0);
      istek_g = 1'b1; adres_g = 32'h4; rst_g = 1'b1;
      saat(2);
      rst_g = 1'b0; istek_g = 1'b0;
      saat(4);
      gonder(32'h8, ROM2, 1'b0);
      saat(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vek, n_hata);
      $finish;
   end

endmodule
